// File: rtl/lfsr_seq_ctrl_if.sv
// Command / result handshake bundle for lfsr_seq_ctrl.
// The master side is the client asking for pseudo-random words; the slave
// side is the sequencer. When LFSR_SEQ_CTRL_AUTO_EN is defined the bundle
// also carries the auto-repeat request (cmd_auto) and its stop line (auto_stop).
interface lfsr_seq_ctrl_if #(
    parameter int STEP_W = 8,
    parameter int WORD_W = 8
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [WORD_W-1:0] cmd_seed;
    logic [STEP_W-1:0] cmd_steps;

    // Result channel
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

`ifdef LFSR_SEQ_CTRL_AUTO_EN
    logic              cmd_auto;
    logic              auto_stop;

    modport master (
        output cmd_valid, cmd_load, cmd_seed, cmd_steps, cmd_auto, auto_stop,
        output word_ready,
        input  cmd_ready, word_valid, word_data
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_seed, cmd_steps, cmd_auto, auto_stop,
        input  word_ready,
        output cmd_ready, word_valid, word_data
    );
`else
    modport master (
        output cmd_valid, cmd_load, cmd_seed, cmd_steps,
        output word_ready,
        input  cmd_ready, word_valid, word_data
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_seed, cmd_steps,
        input  word_ready,
        output cmd_ready, word_valid, word_data
    );
`endif
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 8-bit Galois LFSR block.
//
// A command optionally reloads the LFSR seed (one cycle with lfsr_rst_n low),
// advances it cmd_steps times with lfsr_enable, then shifts WORD_W bits out
// with lfsr_out_enable. The LFSR output is registered, so each serial bit is
// sampled one cycle after its shift pulse; the last bit lands in the DRAIN
// state. The assembled word is then held on the result channel until taken.
//
// Optional build macro: LFSR_SEQ_CTRL_AUTO_EN
//   Adds cmd_auto / auto_stop. With the auto flag latched, each word
//   handshake restarts stepping (no reload) instead of returning to IDLE.
//
// State is one-hot so every strobe is a single flop bit and cannot glitch.
module lfsr_seq_ctrl #(
    parameter int                STEP_W    = 8,
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] SEED_INIT = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_seq_ctrl_if.slave    bus,
    output logic              busy,
    output logic              lfsr_rst_n,
    output logic [WORD_W-1:0] lfsr_seed,
    output logic              lfsr_enable,
    output logic              lfsr_out_enable,
    input  logic              lfsr_out,
    input  logic              lfsr_valid,
    output logic              proto_err
);

    // Sample/pulse counter must be able to hold WORD_W itself (terminal value).
    localparam int CNT_W = $clog2(WORD_W + 1);

    // One-hot bit positions, used for glitch-free strobe decode.
    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_RUN   = 2;
    localparam int S_SHIFT = 3;
    localparam int S_DRAIN = 4;
    localparam int S_HOLD  = 5;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        LOAD  = 6'b000010,
        RUN   = 6'b000100,
        SHIFT = 6'b001000,
        DRAIN = 6'b010000,
        HOLD  = 6'b100000
    } state_t;

    state_t            state_reg;
    logic [STEP_W-1:0] steps_reg;       // step count of the current command, kept for auto repeats
    logic [STEP_W-1:0] step_cnt_reg;    // remaining advance cycles in RUN
    logic [CNT_W-1:0]  pulse_cnt_reg;   // shift pulses issued so far in this word
    logic [WORD_W-1:0] lfsr_seed_reg;
    logic              lfsr_rst_n_reg;
    logic              proto_err_reg;
    logic [WORD_W-1:0] word_data;

    logic              accept;
    logic              capture;
    logic [CNT_W-1:0]  capture_idx;
    logic              auto_go;         // handshake should loop back instead of idling

    assign accept = state_reg[S_IDLE] & bus.cmd_valid;

`ifdef LFSR_SEQ_CTRL_AUTO_EN
    logic auto_reg;

    // Auto-repeat flag: latched with the command, cleared by auto_stop at any time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_reg <= 1'b0;
        end else if (accept) begin
            auto_reg <= bus.cmd_auto & ~bus.auto_stop;
        end else if (bus.auto_stop) begin
            auto_reg <= 1'b0;
        end
    end

    // A stop raised in the handshake cycle itself also ends the loop.
    assign auto_go = auto_reg & ~bus.auto_stop;
`else
    assign auto_go = 1'b0;
`endif

    // Main sequencer: state, counters, seed register and the LFSR reset strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            steps_reg      <= '0;
            step_cnt_reg   <= '0;
            pulse_cnt_reg  <= '0;
            lfsr_seed_reg  <= SEED_INIT;
            lfsr_rst_n_reg <= 1'b0;
        end else begin
            // The LFSR reset is only pulled low for the single LOAD cycle.
            lfsr_rst_n_reg <= 1'b1;
            unique case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        steps_reg     <= bus.cmd_steps;
                        step_cnt_reg  <= bus.cmd_steps;
                        pulse_cnt_reg <= '0;
                        if (bus.cmd_load) begin
                            lfsr_seed_reg  <= bus.cmd_seed;
                            lfsr_rst_n_reg <= 1'b0;
                            state_reg      <= LOAD;
                        end else if (bus.cmd_steps != '0) begin
                            state_reg <= RUN;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                LOAD: begin
                    state_reg <= (steps_reg != '0) ? RUN : SHIFT;
                end
                RUN: begin
                    // Counter stops at zero; leaving on <=1 also guards a zero count.
                    if (step_cnt_reg != '0) begin
                        step_cnt_reg <= step_cnt_reg - 1'b1;
                    end
                    if (step_cnt_reg <= STEP_W'(1)) begin
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
                    if (pulse_cnt_reg == CNT_W'(WORD_W - 1)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // pulse_cnt_reg sits at WORD_W here and is not advanced further.
                    state_reg <= HOLD;
                end
                HOLD: begin
                    if (bus.word_ready) begin
                        if (auto_go) begin
                            step_cnt_reg  <= steps_reg;
                            pulse_cnt_reg <= '0;
                            state_reg     <= (steps_reg != '0) ? RUN : SHIFT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A sample is due in every SHIFT cycle after the first pulse, and in DRAIN
    // for the final bit; the bit index trails the pulse count by one.
    assign capture     = (state_reg[S_SHIFT] & (pulse_cnt_reg != '0)) | state_reg[S_DRAIN];
    assign capture_idx = pulse_cnt_reg - 1'b1;

    // One capture flop per word bit, written when its index comes up.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_word_bit
        logic bit_reg;

        // Capture serial bit gi of the word.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bit_reg <= 1'b0;
            end else if (capture && (capture_idx == CNT_W'(gi))) begin
                bit_reg <= lfsr_out;
            end
        end

        assign word_data[gi] = bit_reg;
    end

    // Sticky protocol error: the LFSR claimed no valid output when we sampled it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err_reg <= 1'b0;
        end else if (capture && !lfsr_valid) begin
            proto_err_reg <= 1'b1;
        end
    end

    // Moore decode straight off the one-hot state bits.
    assign bus.cmd_ready   = state_reg[S_IDLE];
    assign bus.word_valid  = state_reg[S_HOLD];
    assign bus.word_data   = word_data;
    assign busy            = ~state_reg[S_IDLE];
    assign lfsr_enable     = state_reg[S_RUN];
    assign lfsr_out_enable = state_reg[S_SHIFT];
    assign lfsr_rst_n      = lfsr_rst_n_reg;
    assign lfsr_seed       = lfsr_seed_reg;
    assign proto_err       = proto_err_reg;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl. A behavioural Galois LFSR (taps 8'hB8, right
// shifting, rotate on shift-out) stands in for the real block. Stimulus
// pushes hand-computed expectations into a scoreboard queue; a negedge
// monitor pops one entry per word handshake and compares data, strobe
// counts, reload count and latency.
`timescale 1ns/1ps
module tb_lfsr_seq_ctrl;

    localparam int         STEP_W    = 8;
    localparam int         WORD_W    = 8;
    localparam logic [7:0] SEED_INIT = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       lfsr_rst_n;
    logic [7:0] lfsr_seed;
    logic       lfsr_enable;
    logic       lfsr_out_enable;
    logic       lfsr_out;
    logic       lfsr_valid;
    logic       proto_err;

    always #5 clk = ~clk;

    lfsr_seq_ctrl_if #(.STEP_W(STEP_W), .WORD_W(WORD_W)) bus ();

    lfsr_seq_ctrl #(
        .STEP_W   (STEP_W),
        .WORD_W   (WORD_W),
        .SEED_INIT(SEED_INIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .lfsr_rst_n     (lfsr_rst_n),
        .lfsr_seed      (lfsr_seed),
        .lfsr_enable    (lfsr_enable),
        .lfsr_out_enable(lfsr_out_enable),
        .lfsr_out       (lfsr_out),
        .lfsr_valid     (lfsr_valid),
        .proto_err      (proto_err)
    );

    // ---------------- behavioural LFSR ----------------
    logic [7:0] lfsr_state;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
        logic [7:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!(rst && lfsr_rst_n)) begin
            lfsr_state <= lfsr_seed;
            lfsr_out   <= 1'b0;
            lfsr_valid <= 1'b0;
        end else if (lfsr_enable) begin
            lfsr_state <= lfsr_step(lfsr_state);
        end else if (lfsr_out_enable) begin
            lfsr_out   <= lfsr_state[0];
            lfsr_valid <= 1'b1;
            lfsr_state <= {lfsr_state[0], lfsr_state[7:1]};
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string      name;
        logic [7:0] data;
        int         en;
        int         oe;
        int         rl;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_words  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int   en_cnt, oe_cnt, rl_cnt, acc_cyc, lat;
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            en_cnt = 0; oe_cnt = 0; rl_cnt = 0; acc_cyc = cyc; lat = -1;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                en_cnt = 0; oe_cnt = 0; rl_cnt = 0; acc_cyc = cyc; lat = -1;
            end
            if (lfsr_enable) en_cnt++;
            if (lfsr_out_enable) oe_cnt++;
            if (!lfsr_rst_n) rl_cnt++;
            if (lfsr_enable || lfsr_out_enable)
                check("no_overlap", {31'd0, lfsr_enable & lfsr_out_enable}, 32'd0);
            if (bus.word_valid && lat < 0) lat = cyc - acc_cyc;
            if (bus.word_valid && bus.word_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("word %s: data=%02h en=%0d oe=%0d reload=%0d latency=%0d",
                             e.name, bus.word_data, en_cnt, oe_cnt, rl_cnt, lat);
                    check({e.name, "_data"},    {24'd0, bus.word_data}, {24'd0, e.data});
                    check({e.name, "_enables"}, en_cnt, e.en);
                    check({e.name, "_shifts"},  oe_cnt, e.oe);
                    check({e.name, "_reloads"}, rl_cnt, e.rl);
                    check({e.name, "_latency"}, lat,    e.lat);
                    check({e.name, "_proto"},   {31'd0, proto_err}, 32'd0);
                end
                n_words++;
                en_cnt = 0; oe_cnt = 0; rl_cnt = 0; acc_cyc = cyc; lat = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [7:0] data, input int steps, input int load);
        exp_t x;
        x.name = name; x.data = data; x.en = steps; x.oe = WORD_W;
        x.rl = load; x.lat = steps + WORD_W + 2 + load;
        sb.push_back(x);
    endtask

    task automatic send(input string name, input bit load, input logic [7:0] seed,
                        input int steps, input logic [7:0] data, input bit track);
        bit ok;
        if (track) push_exp(name, data, steps, int'(load));
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = load;
        bus.cmd_seed  = seed;
        bus.cmd_steps = 8'(steps);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check({name, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},  {31'd0, bus.cmd_ready},       32'd1);
        check({tag, "_word_valid"}, {31'd0, bus.word_valid},      32'd0);
        check({tag, "_word_data"},  {24'd0, bus.word_data},       32'd0);
        check({tag, "_busy"},       {31'd0, busy},                32'd0);
        check({tag, "_proto_err"},  {31'd0, proto_err},           32'd0);
        check({tag, "_enable"},     {31'd0, lfsr_enable},         32'd0);
        check({tag, "_out_enable"}, {31'd0, lfsr_out_enable},     32'd0);
        check({tag, "_seed"},       {24'd0, lfsr_seed},           {24'd0, SEED_INIT});
        check({tag, "_lfsr_rst_n"}, {31'd0, lfsr_rst_n},          32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [7:0] w255;
    int         base;

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_load   = 1'b0;
        bus.cmd_seed   = 8'h00;
        bus.cmd_steps  = 8'h00;
        bus.word_ready = 1'b1;
`ifdef LFSR_SEQ_CTRL_AUTO_EN
        bus.cmd_auto   = 1'b0;
        bus.auto_stop  = 1'b0;
`endif
        #1 rst = 1'b0;
        repeat (3) tick();
        check_reset_values("por");
        #2 rst = 1'b1;
        tick();
        check("por_lfsr_rst_n_rise", {31'd0, lfsr_rst_n}, 32'd1);

        // Seed echo: reload with A5, no stepping, word echoes the seed.
        send("seed_echo", 1'b1, 8'hA5, 0, 8'hA5, 1'b1);
        wait_idle("seed_echo");

        // Stepping: 01 -> B8 -> 5C -> 2E.
        send("stepping", 1'b1, 8'h01, 3, 8'h2E, 1'b1);
        wait_idle("stepping");

        // Backpressure: word held while word_ready is low; stray command ignored.
        bus.word_ready = 1'b0;
        send("backpressure", 1'b1, 8'h3C, 0, 8'h3C, 1'b1);
        for (int i = 0; i < 50 && !bus.word_valid; i++) tick();
        for (int i = 0; i < 20; i++) begin
            check("bp_word_valid", {31'd0, bus.word_valid}, 32'd1);
            check("bp_word_data",  {24'd0, bus.word_data},  32'h3C);
            check("bp_cmd_ready",  {31'd0, bus.cmd_ready},  32'd0);
            if (i == 5) begin
                bus.cmd_valid = 1'b1; bus.cmd_load = 1'b1;
                bus.cmd_seed = 8'hFF; bus.cmd_steps = 8'd5;
            end
            if (i == 7) bus.cmd_valid = 1'b0;
            tick();
        end
        check("bp_still_busy", {31'd0, busy}, 32'd1);
        bus.word_ready = 1'b1;
        tick();
        check("bp_cmd_ready_after", {31'd0, bus.cmd_ready},  32'd1);
        check("bp_valid_after",     {31'd0, bus.word_valid}, 32'd0);

        // Reset in the middle of a long RUN, then a normal command from SEED_INIT.
        send("abort", 1'b0, 8'h00, 200, 8'h00, 1'b0);
        repeat (20) tick();
        check("abort_in_run", {31'd0, lfsr_enable}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_values("midrun");
        sb.delete();
        repeat (2) tick();
        #2 rst = 1'b1;
        tick();
        check("midrun_lfsr_rst_n_rise", {31'd0, lfsr_rst_n}, 32'd1);
        send("after_reset", 1'b0, 8'h00, 1, 8'hB8, 1'b1);
        wait_idle("after_reset");

        // Back-to-back: maximum step count, then a single step.
        w255 = lfsr_adv(8'hB8, 255);
        send("steps255", 1'b0, 8'h00, 255, w255, 1'b1);
        send("steps1", 1'b0, 8'h00, 1, lfsr_step(w255), 1'b1);
        wait_idle("steps1");
        check("b2b_proto_err", {31'd0, proto_err}, 32'd0);

`ifdef LFSR_SEQ_CTRL_AUTO_EN
        // Auto repeat: 01 -> 5C, then 17, then E1; stop during the third word.
        base = n_words;
        bus.cmd_auto = 1'b1;
        push_exp("auto2", 8'h17, 2, 0);
        push_exp("auto3", 8'hE1, 2, 0);
        send("auto1", 1'b1, 8'h01, 2, 8'h5C, 1'b1);
        bus.cmd_auto = 1'b0;
        // Scoreboard order: auto1 must come first.
        sb.push_front(sb.pop_back());
        for (int i = 0; i < 200 && n_words < base + 2; i++) tick();
        check("auto_cmd_ready_held", {31'd0, bus.cmd_ready}, 32'd0);
        bus.auto_stop = 1'b1;
        tick();
        bus.auto_stop = 1'b0;
        wait_idle("auto");
        check("auto_word_count", n_words - base, 32'd3);
`endif

        repeat (3) tick();
        check("queue_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
